// File: rtl/alu_link_pkg.sv
// Shared definitions for the ALU command link: byte widths, command byte order
// and the sender FSM state encoding.
package alu_link_pkg;

    localparam int LEN_DATA_DEFAULT = 8;
    localparam int OPCODE_W         = 6;
    localparam int NUM_CMD_BYTES    = 3;
    localparam int IDX_W            = 2;

    // Wire order of the command bytes.
    localparam logic [IDX_W-1:0] IDX_A  = 2'd0;
    localparam logic [IDX_W-1:0] IDX_B  = 2'd1;
    localparam logic [IDX_W-1:0] IDX_OP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_RX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rx_timeout_timer.sv
// Cycle counter for the receive wait; expired flags the last allowed cycle.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    // The count parks at LAST until the next clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/alu_cmd_sender.sv
// Sends A, B and OPCODE over a UART byte link, then waits (with timeout) for
// the single-byte ALU result.
module alu_cmd_sender
    import alu_link_pkg::*;
#(
    parameter int LEN_DATA       = LEN_DATA_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [LEN_DATA-1:0] a_in,
    input  logic [LEN_DATA-1:0] b_in,
    input  logic [OPCODE_W-1:0] opcode_in,
    output logic                cmd_ready,
    output logic                tx_start,
    output logic [LEN_DATA-1:0] tx_data,
    input  logic                tx_done_tick,
    input  logic                rx_done_tick,
    input  logic [LEN_DATA-1:0] rx_data,
    output logic [LEN_DATA-1:0] result,
    output logic                result_valid,
    output logic                timeout,
    output logic                busy
);
    state_t              state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic [LEN_DATA-1:0] cmd_bytes_reg [NUM_CMD_BYTES];
    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expired;

    assign cmd_ready    = (state_reg == ST_IDLE);
    assign busy         = ~cmd_ready;
    assign idx_next     = idx_reg + IDX_W'(1);
    assign timer_clear  = (state_reg == ST_WAIT_TX) && tx_done_tick && (idx_reg == IDX_OP);
    assign timer_enable = (state_reg == ST_WAIT_RX);

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= IDX_A;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            for (int i = 0; i < NUM_CMD_BYTES; i++) begin
                cmd_bytes_reg[i] <= '0;
            end
        end else begin
            tx_start     <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_bytes_reg[IDX_A]  <= a_in;
                        cmd_bytes_reg[IDX_B]  <= b_in;
                        cmd_bytes_reg[IDX_OP] <= LEN_DATA'(opcode_in);
                        idx_reg   <= IDX_A;
                        // Byte A goes straight to the pins so tx_start lands next cycle.
                        tx_data   <= a_in;
                        tx_start  <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done_tick) begin
                        if (idx_reg == IDX_OP) begin
                            state_reg <= ST_WAIT_RX;
                        end else begin
                            idx_reg   <= idx_next;
                            tx_data   <= cmd_bytes_reg[idx_next];
                            tx_start  <= 1'b1;
                            state_reg <= ST_SEND;
                        end
                    end
                end
                ST_WAIT_RX: begin
                    // Reception has priority over a coincident expiry.
                    if (rx_done_tick) begin
                        result       <= rx_data;
                        result_valid <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else if (timer_expired) begin
                        timeout   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Randomized bench for alu_cmd_sender: a UART echo model plus a cycle-level
// expectation of wire bytes, result_valid/timeout timing and held result.
module tb_alu_cmd_sender;

    localparam int W      = 8;
    localparam int TO     = 16;
    localparam int TX_LAT = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [5:0]   opcode_in;
    logic         cmd_ready;
    logic         tx_start;
    logic [W-1:0] tx_data;
    logic         tx_done_tick;
    logic         rx_done_tick;
    logic [W-1:0] rx_data;
    logic [W-1:0] result;
    logic         result_valid;
    logic         timeout;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int tx_cnt       = 0;

    int           wire_start_q[$];
    logic [W-1:0] wire_byte_q[$];
    int           rv_q[$];
    int           to_q[$];
    logic [W-1:0] exp_result;
    logic [W-1:0] last_tx;

    alu_cmd_sender #(
        .LEN_DATA      (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .a_in         (a_in),
        .b_in         (b_in),
        .opcode_in    (opcode_in),
        .cmd_ready    (cmd_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART transmitter model and output monitor.
    initial begin
        tx_done_tick = 1'b0;
        last_tx      = '0;
        forever begin
            @(posedge clk);
            #1;
            tx_done_tick = 1'b0;
            if (reset) begin
                tx_cnt = 0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done_tick = 1'b1;
                        check("tx_data_stable", tx_data, last_tx);
                    end
                end
                if (tx_start) begin
                    wire_start_q.push_back(cyc);
                    wire_byte_q.push_back(tx_data);
                    last_tx = tx_data;
                    tx_cnt  = TX_LAT;
                end
                if (result_valid) rv_q.push_back(cyc);
                if (timeout) to_q.push_back(cyc);
            end
        end
    end

    // d >= 0: rx_done_tick arrives d cycles after WAIT_RX entry; d < 0: never.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op,
                           input int d, input logic [W-1:0] rxv, input bit noise);
        int           k;
        int           c;
        int           waited;
        logic [W-1:0] exp_bytes [3];
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        check("idle_before_cmd", cmd_ready, 1);
        wire_start_q.delete();
        wire_byte_q.delete();
        rv_q.delete();
        to_q.delete();
        exp_bytes[0] = a;
        exp_bytes[1] = b;
        exp_bytes[2] = {2'b00, op};
        cmd_valid = 1'b1;
        a_in      = a;
        b_in      = b;
        opcode_in = op;
        k = cyc;
        c = k + 3 * (TX_LAT + 1);  // cycle of the third tx_done_tick
        for (int t = k + 1; t <= c + 21; t++) begin
            tick();
            cmd_valid    = 1'b0;
            rx_done_tick = 1'b0;
            a_in         = W'($urandom);
            b_in         = W'($urandom);
            opcode_in    = 6'($urandom);
            rx_data      = W'($urandom);
            if (noise && t <= c) begin
                cmd_valid    = ($urandom_range(0, 3) == 0);
                rx_done_tick = ($urandom_range(0, 3) == 0);
            end
            if (noise && t == k + 5) begin
                cmd_valid    = 1'b1;
                a_in         = 8'hFF;
                rx_done_tick = 1'b1;
            end
            if (noise && ((d >= 0 && t >= c + 2 + d) || (d < 0 && t >= c + TO + 1)))
                rx_done_tick = ($urandom_range(0, 1) == 1);
            if (d >= 0 && t == c + 1 + d) begin
                rx_done_tick = 1'b1;
                rx_data      = rxv;
            end
            if (t == k + 1) check("busy_after_accept", busy, 1);
            if (d < 0 && t == c + TO + 2) check("ready_after_timeout", cmd_ready, 1);
        end
        cmd_valid    = 1'b0;
        rx_done_tick = 1'b0;

        check("wire_byte_count", wire_byte_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wire_byte_q.size()) begin
                check($sformatf("wire_byte%0d", i), wire_byte_q[i], exp_bytes[i]);
                check($sformatf("tx_start_cycle%0d", i), wire_start_q[i], k + 1 + i * (TX_LAT + 1));
            end
        end
        if (d >= 0) begin
            check("result_valid_count", rv_q.size(), 1);
            if (rv_q.size() > 0) check("result_valid_cycle", rv_q[0], c + 2 + d);
            check("timeout_count", to_q.size(), 0);
            exp_result = rxv;
        end else begin
            check("timeout_count", to_q.size(), 1);
            if (to_q.size() > 0) check("timeout_cycle", to_q[0], c + 1 + TO);
            check("result_valid_count", rv_q.size(), 0);
        end
        check("result", result, exp_result);
        $display("[TB] txn a=%02h b=%02h op=%02h rx_delay=%0d noise=%0d result=%02h",
                 a, b, op, d, noise, result);
    endtask

    task automatic reset_mid_tx();
        wire_start_q.delete();
        wire_byte_q.delete();
        cmd_valid = 1'b1;
        a_in      = 8'h22;
        b_in      = 8'h33;
        opcode_in = 6'h01;
        tick();
        cmd_valid = 1'b0;
        repeat (14) tick();  // now in WAIT_TX of byte B
        check("sent_before_reset", wire_byte_q.size(), 2);
        reset = 1'b1;
        #1;
        check("outputs_in_reset", {tx_start, tx_data, result, result_valid, timeout, busy, cmd_ready},
              {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        #2 reset = 1'b0;
        exp_result = '0;
        repeat (30) tick();
        check("no_tx_after_reset", wire_byte_q.size(), 2);
        $display("[TB] txn reset during byte B, bytes seen=%0d", wire_byte_q.size());
        run_cmd(8'h11, 8'h5C, 6'h07, 4, 8'h3D, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        a_in         = '0;
        b_in         = '0;
        opcode_in    = '0;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        exp_result   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {tx_start, tx_data, result, result_valid, timeout, busy, cmd_ready},
              {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        #2 reset = 1'b0;
        tick();
        check("idle_after_reset", {cmd_ready, busy, tx_start}, 3'b100);

        run_cmd(8'h05, 8'h03, 6'h20, 3, 8'h08, 1'b0);
        run_cmd(8'h5A, 8'hC3, 6'h3F, -1, 8'h77, 1'b0);
        run_cmd(8'h12, 8'h34, 6'h15, TO - 1, 8'hAA, 1'b0);
        run_cmd(8'h9E, 8'h41, 6'h2A, 7, 8'h42, 1'b1);
        reset_mid_tx();

        for (int n = 0; n < 24; n++) begin
            int sel;
            int d;
            sel = $urandom_range(0, 5);
            if (sel == 0) d = -1;
            else if (sel == 1) d = TO - 1;
            else d = $urandom_range(0, TO - 2);
            run_cmd(W'($urandom), W'($urandom), 6'($urandom), d, W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
